// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: opcodes, NOP encodings,
// the hazard FSM state type and a small sizing helper.
package pipeline_hazard_ctrl_pkg;

  localparam logic [6:0]  OP_LOAD  = 7'h03;
  localparam logic [6:0]  OP_NOP   = 7'h13;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    LD_STALL = 2'd2,
    MEM_WAIT = 2'd3
  } hz_state_t;

  // Sizes the bubble/flush counter from the larger of the two cycle counts.
  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_lduse_detect.sv
// Combinational load-use comparator: flags a decode instruction that reads the
// destination of a load currently in exec. Shared later with the forwarding unit.
module lduse_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       i_d_valid,
  input  logic [4:0] i_d_rs1,
  input  logic [4:0] i_d_rs2,
  input  logic       i_d_uses_rs2,
  input  logic       i_e_valid,
  input  logic [6:0] i_e_opcode,
  input  logic [4:0] i_e_rd,
  output logic       o_lduse
);

  logic w_isLoad;
  logic w_rdLive;
  logic w_hitRs1;
  logic w_hitRs2;

  // x0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign w_isLoad = i_e_valid & (i_e_opcode == OP_LOAD);
  assign w_rdLive = (i_e_rd != 5'd0);
  assign w_hitRs1 = (i_e_rd == i_d_rs1);
  assign w_hitRs2 = i_d_uses_rs2 & (i_e_rd == i_d_rs2);

  assign o_lduse = i_d_valid & w_isLoad & w_rdLive & (w_hitRs1 | w_hitRs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage RV32 pipeline: per-stage stall/flush
// and fetch redirect. Optional statistics counters under HAZARD_STATS_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int BIN_DIG      = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int LOAD_BUBBLES = 1
)
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               d_valid,
  input  logic [4:0]         d_rs1,
  input  logic [4:0]         d_rs2,
  input  logic               d_uses_rs2,
  input  logic               e_valid,
  input  logic [6:0]         e_opcode,
  input  logic [4:0]         e_rd,
  input  logic               br_taken,
  input  logic [BIN_DIG-1:0] br_target,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               stall_f,
  output logic               stall_d,
  output logic               stall_e,
  output logic               flush_fd,
  output logic               flush_de,
  output logic               redirect,
  output logic [BIN_DIG-1:0] redirect_pc,
  output logic [1:0]         state_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]        stat_stall_cyc,
  output logic [31:0]        stat_flush_cnt,
  output logic [31:0]        stat_lduse_cnt
`endif
);

  localparam int CNT_MAX = maxOf(FLUSH_CYCLES, LOAD_BUBBLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] FL_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  hz_state_t        r_state;
  hz_state_t        w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic [CNT_W-1:0] w_cntDec;

  logic w_memwait;
  logic w_ctrl;
  logic w_lduse;

  logic w_stallF;
  logic w_stallD;
  logic w_stallE;
  logic w_flushFd;
  logic w_flushDe;
  logic w_redirect;

  assign w_memwait = mem_req & ~mem_ready;
  assign w_ctrl    = br_taken & e_valid;
  assign w_cntDec  = (r_cnt != '0) ? (r_cnt - CNT_ONE) : '0;

  lduse_detect u_lduse (
    .i_d_valid    (d_valid),
    .i_d_rs1      (d_rs1),
    .i_d_rs2      (d_rs2),
    .i_d_uses_rs2 (d_uses_rs2),
    .i_e_valid    (e_valid),
    .i_e_opcode   (e_opcode),
    .i_e_rd       (e_rd),
    .o_lduse      (w_lduse)
  );

  // Next-state and control decode; memwait outranks ctrl, which outranks lduse.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_stallF    = 1'b0;
    w_stallD    = 1'b0;
    w_stallE    = 1'b0;
    w_flushFd   = 1'b0;
    w_flushDe   = 1'b0;
    w_redirect  = 1'b0;
    case (r_state)
      RUN: begin
        if (w_memwait) begin
          w_stallF    = 1'b1;
          w_stallD    = 1'b1;
          w_stallE    = 1'b1;
          w_nextState = MEM_WAIT;
        end else if (w_ctrl) begin
          w_redirect = 1'b1;
          w_flushFd  = 1'b1;
          w_flushDe  = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_nextState = FLUSH;
            w_nextCnt   = FL_INIT;
          end
        end else if (w_lduse) begin
          w_stallF  = 1'b1;
          w_stallD  = 1'b1;
          w_flushDe = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            w_nextState = LD_STALL;
            w_nextCnt   = LD_INIT;
          end
        end
      end
      FLUSH: begin
        w_flushFd = 1'b1;
        w_nextCnt = w_cntDec;
        if (r_cnt <= CNT_ONE) begin
          w_nextState = RUN;
        end
      end
      LD_STALL: begin
        if (w_ctrl) begin
          w_redirect  = 1'b1;
          w_flushFd   = 1'b1;
          w_flushDe   = 1'b1;
          w_nextState = RUN;
          w_nextCnt   = '0;
        end else begin
          w_stallF  = 1'b1;
          w_stallD  = 1'b1;
          w_flushDe = 1'b1;
          w_nextCnt = w_cntDec;
          if (r_cnt <= CNT_ONE) begin
            w_nextState = RUN;
          end
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          w_stallF = 1'b1;
          w_stallD = 1'b1;
          w_stallE = 1'b1;
        end else begin
          w_nextState = RUN;
        end
      end
      default: begin
        w_nextState = RUN;
        w_nextCnt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // Outputs are masked by reset so they drop the instant RST rises, not at the next edge.
  assign stall_f     = w_stallF   & ~RST;
  assign stall_d     = w_stallD   & ~RST;
  assign stall_e     = w_stallE   & ~RST;
  assign flush_fd    = w_flushFd  & ~RST;
  assign flush_de    = w_flushDe  & ~RST;
  assign redirect    = w_redirect & ~RST;
  assign redirect_pc = redirect ? br_target : '0;
  assign state_o     = r_state;

`ifdef HAZARD_STATS_EN
  logic w_ldEntry;

  assign w_ldEntry = (r_state == RUN) & ~w_memwait & ~w_ctrl & w_lduse & ~RST;

  // Saturating event counters; each holds at all ones rather than wrapping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_stall_cyc <= '0;
      stat_flush_cnt <= '0;
      stat_lduse_cnt <= '0;
    end else begin
      if (stall_f && (stat_stall_cyc != '1)) begin
        stat_stall_cyc <= stat_stall_cyc + 32'd1;
      end
      if (redirect && (stat_flush_cnt != '1)) begin
        stat_flush_cnt <= stat_flush_cnt + 32'd1;
      end
      if (w_ldEntry && (stat_lduse_cnt != '1)) begin
        stat_lduse_cnt <= stat_lduse_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: one default instance and one with
// FLUSH_CYCLES=3 / LOAD_BUBBLES=3, both driven by the same stimulus.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] C_0  = 6'b000000;
  localparam logic [5:0] C_LD = 6'b110010;
  localparam logic [5:0] C_BR = 6'b000111;
  localparam logic [5:0] C_FL = 6'b000100;
  localparam logic [5:0] C_MW = 6'b111000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        dValid, dUsesRs2, eValid, brTaken, memReq, memReady;
  logic [4:0]  dRs1, dRs2, eRd;
  logic [6:0]  eOpcode;
  logic [31:0] brTarget;

  logic        aStallF, aStallD, aStallE, aFlushFd, aFlushDe, aRedirect;
  logic        bStallF, bStallD, bStallE, bFlushFd, bFlushDe, bRedirect;
  logic [31:0] aPc, bPc;
  logic [1:0]  aState, bState;
  logic [5:0]  aCtl, bCtl;

  assign aCtl = {aStallF, aStallD, aStallE, aFlushFd, aFlushDe, aRedirect};
  assign bCtl = {bStallF, bStallD, bStallE, bFlushFd, bFlushDe, bRedirect};

  typedef struct packed {
    logic        dv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u2;
    logic        ev;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic        bt;
    logic [31:0] tgt;
    logic        mreq;
    logic        mrdy;
  } stim_t;

  typedef struct {
    int          step;
    logic [5:0]  ctlA;
    logic [31:0] pcA;
    logic [1:0]  stA;
    logic [5:0]  ctlB;
    logic [31:0] pcB;
    logic [1:0]  stB;
  } exp_t;

  exp_t sbQ[$];
  exp_t monExp;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl dutA (
    .CLK(CLK), .RST(RST),
    .d_valid(dValid), .d_rs1(dRs1), .d_rs2(dRs2), .d_uses_rs2(dUsesRs2),
    .e_valid(eValid), .e_opcode(eOpcode), .e_rd(eRd),
    .br_taken(brTaken), .br_target(brTarget),
    .mem_req(memReq), .mem_ready(memReady),
    .stall_f(aStallF), .stall_d(aStallD), .stall_e(aStallE),
    .flush_fd(aFlushFd), .flush_de(aFlushDe),
    .redirect(aRedirect), .redirect_pc(aPc), .state_o(aState)
  );

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .LOAD_BUBBLES(3)) dutB (
    .CLK(CLK), .RST(RST),
    .d_valid(dValid), .d_rs1(dRs1), .d_rs2(dRs2), .d_uses_rs2(dUsesRs2),
    .e_valid(eValid), .e_opcode(eOpcode), .e_rd(eRd),
    .br_taken(brTaken), .br_target(brTarget),
    .mem_req(memReq), .mem_ready(memReady),
    .stall_f(bStallF), .stall_d(bStallD), .stall_e(bStallE),
    .flush_fd(bFlushFd), .flush_de(bFlushDe),
    .redirect(bRedirect), .redirect_pc(bPc), .state_o(bState)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic stim_t stimOf(input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic u2, input logic ev, input logic [6:0] op,
                                   input logic [4:0] rd, input logic bt, input logic [31:0] tgt,
                                   input logic mreq, input logic mrdy);
    stim_t s;
    s.dv = dv; s.rs1 = rs1; s.rs2 = rs2; s.u2 = u2; s.ev = ev; s.op = op;
    s.rd = rd; s.bt = bt; s.tgt = tgt; s.mreq = mreq; s.mrdy = mrdy;
    return s;
  endfunction

  function automatic stim_t idleStim();
    return stimOf(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 7'h13, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic stim_t ldUse55();
    return stimOf(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 7'h03, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic stim_t branchTo(input logic [31:0] tgt);
    return stimOf(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 7'h63, 5'd0, 1'b1, tgt, 1'b0, 1'b0);
  endfunction

  function automatic exp_t expOf(input int step, input logic [5:0] ctlA, input logic [31:0] pcA,
                                 input logic [1:0] stA, input logic [5:0] ctlB,
                                 input logic [31:0] pcB, input logic [1:0] stB);
    exp_t e;
    e.step = step; e.ctlA = ctlA; e.pcA = pcA; e.stA = stA;
    e.ctlB = ctlB; e.pcB = pcB; e.stB = stB;
    return e;
  endfunction

  task automatic driveInputs(input stim_t s);
    dValid = s.dv; dRs1 = s.rs1; dRs2 = s.rs2; dUsesRs2 = s.u2;
    eValid = s.ev; eOpcode = s.op; eRd = s.rd;
    brTaken = s.bt; brTarget = s.tgt; memReq = s.mreq; memReady = s.mrdy;
  endtask

  task automatic applyStimulus(input stim_t s, input exp_t e);
    @(posedge CLK);
    #1;
    driveInputs(s);
    sbQ.push_back(e);
  endtask

  // Expected values queued at drive time are compared mid-cycle, away from CLK edges.
  always @(negedge CLK) begin
    if (sbQ.size() != 0) begin
      monExp = sbQ.pop_front();
      checkOutput($sformatf("s%0d ctlA", monExp.step),   {26'd0, aCtl},   {26'd0, monExp.ctlA});
      checkOutput($sformatf("s%0d pcA", monExp.step),    aPc,             monExp.pcA);
      checkOutput($sformatf("s%0d stateA", monExp.step), {30'd0, aState}, {30'd0, monExp.stA});
      checkOutput($sformatf("s%0d ctlB", monExp.step),   {26'd0, bCtl},   {26'd0, monExp.ctlB});
      checkOutput($sformatf("s%0d pcB", monExp.step),    bPc,             monExp.pcB);
      checkOutput($sformatf("s%0d stateB", monExp.step), {30'd0, bState}, {30'd0, monExp.stB});
    end
  end

  initial begin
    stim_t memStim;
    driveInputs(ldUse55());
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst ctlA",   {26'd0, aCtl},   32'd0);
    checkOutput("rst pcA",    aPc,             32'd0);
    checkOutput("rst stateA", {30'd0, aState}, 32'd0);
    checkOutput("rst ctlB",   {26'd0, bCtl},   32'd0);
    checkOutput("rst stateB", {30'd0, bState}, 32'd0);
    @(posedge CLK);
    #1;
    driveInputs(idleStim());
    RST = 1'b0;

    applyStimulus(idleStim(), expOf(0, C_0, 0, 0, C_0, 0, 0));
    applyStimulus(ldUse55(),  expOf(1, C_LD, 0, 0, C_LD, 0, 0));
    applyStimulus(idleStim(), expOf(2, C_0, 0, 0, C_LD, 0, 2));
    applyStimulus(idleStim(), expOf(3, C_0, 0, 0, C_LD, 0, 2));
    applyStimulus(idleStim(), expOf(4, C_0, 0, 0, C_0, 0, 0));
    applyStimulus(stimOf(1, 5'd0, 5'd0, 0, 1, 7'h03, 5'd0, 0, 0, 0, 0), expOf(5, C_0, 0, 0, C_0, 0, 0));
    applyStimulus(stimOf(1, 5'd1, 5'd7, 0, 1, 7'h03, 5'd7, 0, 0, 0, 0), expOf(6, C_0, 0, 0, C_0, 0, 0));
    applyStimulus(stimOf(1, 5'd1, 5'd7, 1, 1, 7'h03, 5'd7, 0, 0, 0, 0), expOf(7, C_LD, 0, 0, C_LD, 0, 0));
    applyStimulus(idleStim(), expOf(8, C_0, 0, 0, C_LD, 0, 2));
    applyStimulus(branchTo(32'h200), expOf(9, C_BR, 32'h200, 0, C_BR, 32'h200, 2));
    applyStimulus(idleStim(), expOf(10, C_0, 0, 0, C_0, 0, 0));
    applyStimulus(branchTo(32'h100), expOf(11, C_BR, 32'h100, 0, C_BR, 32'h100, 0));
    applyStimulus(branchTo(32'h300), expOf(12, C_BR, 32'h300, 0, C_FL, 0, 1));
    applyStimulus(idleStim(), expOf(13, C_0, 0, 0, C_FL, 0, 1));
    applyStimulus(idleStim(), expOf(14, C_0, 0, 0, C_0, 0, 0));
    applyStimulus(stimOf(0, 5'd0, 5'd0, 0, 0, 7'h63, 5'd0, 1, 32'h600, 0, 0), expOf(15, C_0, 0, 0, C_0, 0, 0));
    applyStimulus(stimOf(1, 5'd5, 5'd0, 0, 1, 7'h03, 5'd5, 1, 32'h400, 0, 0),
                  expOf(16, C_BR, 32'h400, 0, C_BR, 32'h400, 0));
    applyStimulus(idleStim(), expOf(17, C_0, 0, 0, C_FL, 0, 1));
    applyStimulus(idleStim(), expOf(18, C_0, 0, 0, C_FL, 0, 1));

    memStim = stimOf(0, 5'd0, 5'd0, 0, 1, 7'h63, 5'd0, 1, 32'h500, 1, 0);
    applyStimulus(memStim, expOf(19, C_MW, 0, 0, C_MW, 0, 0));
    for (int i = 20; i <= 22; i++) begin
      applyStimulus(memStim, expOf(i, C_MW, 0, 3, C_MW, 0, 3));
    end
    memStim.mrdy = 1'b1;
    applyStimulus(memStim, expOf(23, C_0, 0, 3, C_0, 0, 3));
    applyStimulus(branchTo(32'h500), expOf(24, C_BR, 32'h500, 0, C_BR, 32'h500, 0));
    applyStimulus(idleStim(), expOf(25, C_0, 0, 0, C_FL, 0, 1));
    applyStimulus(idleStim(), expOf(26, C_0, 0, 0, C_FL, 0, 1));
    applyStimulus(idleStim(), expOf(27, C_0, 0, 0, C_0, 0, 0));
    applyStimulus(ldUse55(),  expOf(28, C_LD, 0, 0, C_LD, 0, 0));
    applyStimulus(ldUse55(),  expOf(29, C_LD, 0, 0, C_LD, 0, 2));

    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("midrst ctlA",   {26'd0, aCtl},   32'd0);
    checkOutput("midrst ctlB",   {26'd0, bCtl},   32'd0);
    checkOutput("midrst pcB",    bPc,             32'd0);
    checkOutput("midrst stateB", {30'd0, bState}, 32'd0);
    @(posedge CLK);
    #1;
    driveInputs(idleStim());
    RST = 1'b0;

    applyStimulus(ldUse55(),  expOf(30, C_LD, 0, 0, C_LD, 0, 0));
    applyStimulus(idleStim(), expOf(31, C_0, 0, 0, C_LD, 0, 2));
    applyStimulus(idleStim(), expOf(32, C_0, 0, 0, C_LD, 0, 2));
    applyStimulus(idleStim(), expOf(33, C_0, 0, 0, C_0, 0, 0));

    @(negedge CLK);
    #1;
    checkOutput("sbDrained", sbQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
